// File: rtl/mulseq_pkg.sv
// Shared MDU definitions: multiply funct3 encodings
// and the sequencer state type.
package mulseq_pkg;

   localparam logic [1:0] F3_MUL    = 2'b00;
   localparam logic [1:0] F3_MULH   = 2'b01;
   localparam logic [1:0] F3_MULHSU = 2'b10;
   localparam logic [1:0] F3_MULHU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mulseq_mulstep.sv
// One radix-2 shift-add iteration: add M into the
// high half when P[0] is set, then shift right by one.
module mulstep #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] p,
   input  logic [XLEN-1:0]   m,
   output logic [2*XLEN-1:0] p_next
);

   logic [XLEN-1:0] addend;
   logic [XLEN:0]   sum;

   always_comb begin
      addend = p[0] ? m : '0;
      sum    = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, addend};
      p_next = {sum, p[XLEN-1:1]};
   end

endmodule

// File: rtl/mulseq.sv
// Iterative radix-2 shift-add multiplier with a
// start/busy/done handshake, one multiplier bit per cycle.
module mulseq
   import mulseq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Start,
   input  logic            Flush,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [1:0]      Funct3,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   localparam int CW = $clog2(XLEN) + 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] p_q, p_d;
   logic [XLEN-1:0]   m_q, m_d;
   logic              neg_q, neg_d;
   logic [1:0]        f3_q, f3_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              neg_a, neg_b;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [2*XLEN-1:0] p_next, final_p;
   logic              accept, step, last;

   mulstep #(.XLEN(XLEN)) u_step (
      .p      (p_q),
      .m      (m_q),
      .p_next (p_next)
   );

   always_comb begin
      neg_a   = A[XLEN-1] & (Funct3 != F3_MULHU);
      neg_b   = B[XLEN-1] & ~Funct3[1];
      abs_a   = neg_a ? -A : A;
      abs_b   = neg_b ? -B : B;
      final_p = neg_q ? -p_next : p_next;
      accept  = (state_q == IDLE) & Start & ~Flush;
      step    = (state_q == BUSY) & ~Flush;
      last    = (cnt_q == CW'(XLEN - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         neg_q   <= 1'b0;
         f3_q    <= F3_MUL;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         m_q     <= m_d;
         neg_q   <= neg_d;
         f3_q    <= f3_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Flush wins over both the step and a new Start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = BUSY;
         BUSY: begin
            if (Flush)     state_d = IDLE;
            else if (last) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      p_d   = p_q;
      m_d   = m_q;
      neg_d = neg_q;
      f3_d  = f3_q;
      res_d = res_q;
      if (accept) begin
         m_d   = abs_a;
         p_d   = {{XLEN{1'b0}}, abs_b};
         neg_d = neg_a ^ neg_b;
         f3_d  = Funct3;
         cnt_d = '0;
      end else if (step) begin
         p_d   = p_next;
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            res_d = (f3_q == F3_MUL) ? final_p[XLEN-1:0]
                                     : final_p[2*XLEN-1:XLEN];
         end
      end
   end

   always_comb begin
      busy_d = (state_d == BUSY);
      done_d = (state_d == DONE);
   end

   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Result = res_q;

endmodule

// File: tb/tb_mulseq.sv
// Scoreboard bench for mulseq: directed vectors push
// expected results, a monitor checks them on Done.
module tb_mulseq;

   logic        clk;
   logic        reset;
   logic        Start;
   logic        Flush;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  Funct3;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;

   int          n_checks;
   int          n_fail;
   logic [31:0] sb[$];
   logic [31:0] last_exp;

   mulseq #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .Start  (Start),
      .Flush  (Flush),
      .A      (A),
      .B      (B),
      .Funct3 (Funct3),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && Done) begin
         chk("busy_done_excl", {31'd0, Busy}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", Result, 32'hxxxx_xxxx);
         end else begin
            chk("result", Result, sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   // Issue Start in the current cycle; returns in cycle 1 of the op.
   task automatic start_op(input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [1:0]  f3,
                           input logic [31:0] exp,
                           input bit          push);
      Start  = 1'b1;
      A      = a;
      B      = b;
      Funct3 = f3;
      if (push) begin
         sb.push_back(exp);
         last_exp = exp;
      end
      @(negedge clk);
      Start = 1'b0;
      A     = 32'h0;
      B     = 32'h0;
   endtask

   task automatic wait_done(input int cyc0, input int exp_cyc);
      int cyc;
      int nbusy;
      cyc   = cyc0;
      nbusy = 0;
      while (!Done && cyc < exp_cyc + 20) begin
         if (Busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
      chk("done_cycle", cyc, exp_cyc);
      chk("busy_cycles", nbusy, exp_cyc - cyc0);
      @(negedge clk);
      chk("idle_after", {30'd0, Busy, Done}, 32'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  f3;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      last_exp = 32'h0;
      reset    = 1'b1;
      Start    = 1'b0;
      Flush    = 1'b0;
      A        = 32'h0;
      B        = 32'h0;
      Funct3   = 2'b00;

      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE});
      vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 2'b00, 32'hFFFF_FFEB});
      vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 2'b01, 32'hFFFF_FFFF});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE});
      vecs.push_back('{32'h0000_0002, 32'h8000_0000, 2'b10, 32'h0000_0001});
      vecs.push_back('{32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000});
      vecs.push_back('{32'h0001_0000, 32'h0001_0000, 2'b11, 32'h0000_0001});

      repeat (2) @(negedge clk);
      chk("reset_outputs", {Busy, Done, Result[29:0]}, 32'd0);
      chk("reset_result", Result, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].exp, 1'b1);
         wait_done(1, 33);
      end

      // Flush in cycle 10, restart in cycle 11, stray Start ignored.
      start_op(32'd5, 32'd6, 2'b00, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      chk("busy_before_flush", {31'd0, Busy}, 32'd1);
      Flush = 1'b1;
      @(negedge clk);
      Flush = 1'b0;
      chk("flush_busy_done", {30'd0, Busy, Done}, 32'd0);
      chk("flush_result_hold", Result, last_exp);
      start_op(32'd5, 32'd6, 2'b00, 32'd30, 1'b1);
      repeat (3) @(negedge clk);
      Start  = 1'b1;
      A      = 32'd99;
      B      = 32'd99;
      Funct3 = 2'b11;
      @(negedge clk);
      Start = 1'b0;
      A     = 32'h0;
      B     = 32'h0;
      wait_done(16, 44);

      // Reset in cycle 5 of an operation.
      start_op(32'h0000_1234, 32'd3, 2'b00, 32'd0, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_flags", {30'd0, Busy, Done}, 32'd0);
      chk("midreset_result", Result, 32'd0);
      start_op(32'h0, 32'h1234_5678, 2'b00, 32'h0, 1'b1);
      wait_done(1, 33);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
